// File: rtl/tea_arb_pkg.sv
// Shared types and constants for the TEA cipher-core arbiter (tea_arb and rr_pick).
package tea_arb_pkg;

    localparam int          NREQ_DEF = 4;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // (base + off) mod n for base < n and off <= n, without a divider.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/tea_arb_rr_pick.sv
// rr_pick: purely combinational round-robin selector; priority starts at ptr+1 and wraps.
module rr_pick
    import tea_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    // Scan from the farthest offset inward so the slot just after ptr is written last and wins.
    always_comb begin
        idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = req[wrap_idx(int'(ptr), i, NREQ)] ? IW'(wrap_idx(int'(ptr), i, NREQ)) : idx;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/tea_arb.sv
// tea_arb: shares one TEA cipher core among NREQ requesters with round-robin fairness.
// Defining TEA_ARB_WDOG_EN adds a WAIT-state watchdog, the TMO parameter and the err port.
module tea_arb
    import tea_arb_pkg::*;
#(
    parameter int          NREQ = NREQ_DEF
`ifdef TEA_ARB_WDOG_EN
    ,
    parameter logic [15:0] TMO  = 16'd511
`endif
) (
    input  logic                    clk,
    input  logic                    prstb,
    input  logic [NREQ-1:0]         req,
    input  logic [32*NREQ-1:0]      wdata,
    output logic [NREQ-1:0]         done,
    output logic [31:0]             rdata,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    core_req,
    output logic [31:0]             core_wdata,
    input  logic                    core_ack,
    input  logic [31:0]             core_rdata
`ifdef TEA_ARB_WDOG_EN
    ,
    output logic                    err
`endif
);

    localparam int IW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            pick_valid_s;
    logic [IW-1:0]   pick_idx_s;
    logic            tmo_hit_s;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

`ifdef TEA_ARB_WDOG_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    assign tmo_hit_s = (state_q == WAIT) && (cnt_q == TMO);

    // Watchdog: count WAIT cycles; the error flag is sticky until reset.
    always_comb begin
        cnt_d = 16'd0;
        err_d = err_q;
        if (state_q == WAIT) begin
            cnt_d = cnt_q + 16'd1;
            err_d = err_q | (tmo_hit_s & ~core_ack);
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge prstb) begin
        if (!prstb) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit_s = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge prstb) begin
        if (!prstb) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and registered-output update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        done_d  = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // A core still busy from before reset must finish before anyone is granted.
                if (core_ack && pick_valid_s) begin
                    state_d = ISSUE;
                    gnt_d   = pick_idx_s;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (core_ack || tmo_hit_s) begin
                    state_d       = DONE;
                    busy_d        = 1'b0;
                    done_d[gnt_q] = 1'b1;
                    rdata_d       = core_ack ? core_rdata : ERR_WORD;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = gnt_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Core request decoded from state; wdata is sampled by the core only during ISSUE.
    always_comb begin
        core_req   = 1'b0;
        core_wdata = 32'd0;
        case (state_q)
            ISSUE: begin
                core_req   = 1'b1;
                core_wdata = wdata[{gnt_q, 5'd0} +: 32];
            end
            default: begin
                core_req   = 1'b0;
                core_wdata = 32'd0;
            end
        endcase
    end

    assign done   = done_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign gnt_id = gnt_q;

endmodule

// File: tb/tb_tea_arb.sv
// Self-checking bench for tea_arb: 8-round core model, round-robin reference model, directed + random steps.
module tb_tea_arb;
    import tea_arb_pkg::*;

    localparam int N      = 4;
    localparam int ROUNDS = 8;
    localparam int LAT    = ROUNDS + 3;
    localparam int TMO_TB = 20;

    logic            clk   = 1'b0;
    logic            prstb = 1'b0;
    logic [N-1:0]    req   = '0;
    logic [32*N-1:0] wdata = '0;
    logic [N-1:0]    done;
    logic [31:0]     rdata;
    logic            busy;
    logic [1:0]      gnt_id;
    logic            core_req;
    logic [31:0]     core_wdata;
    logic            core_ack;
    logic [31:0]     core_rdata = 32'd0;
`ifdef TEA_ARB_WDOG_EN
    logic            err;
`endif

    logic        ack_hold    = 1'b0;
    logic        core_busy_m = 1'b0;
    int          core_cnt_m  = 0;
    logic [31:0] core_in_m   = 32'd0;
    int          creq_cnt    = 0;
    int          checks      = 0;
    int          failures    = 0;
    int          mptr        = N - 1;

    always #5 clk = ~clk;

    tea_arb #(
        .NREQ (N)
`ifdef TEA_ARB_WDOG_EN
        , .TMO (16'd20)
`endif
    ) dut (
        .clk        (clk),
        .prstb      (prstb),
        .req        (req),
        .wdata      (wdata),
        .done       (done),
        .rdata      (rdata),
        .busy       (busy),
        .gnt_id     (gnt_id),
        .core_req   (core_req),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata)
`ifdef TEA_ARB_WDOG_EN
        , .err      (err)
`endif
    );

    function automatic logic [31:0] cipher(input logic [31:0] x);
        logic [31:0] v;
        logic [31:0] sum;
        v   = x;
        sum = 32'd0;
        for (int r = 0; r < ROUNDS; r++) begin
            sum = sum + 32'h9E37_79B9;
            v   = v + ((((v << 4) ^ (v >> 5)) + v) ^ sum);
        end
        return v;
    endfunction

    function automatic int rr_expect(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] slice(input logic [32*N-1:0] w, input int idx);
        return w[32*idx +: 32];
    endfunction

    // Core model: one load cycle plus ROUNDS busy cycles, ack low while busy.
    assign core_ack = ~core_busy_m & ~ack_hold;
    always @(posedge clk) begin
        if (core_req) creq_cnt <= creq_cnt + 1;
        if (!core_busy_m && core_req) begin
            core_busy_m <= 1'b1;
            core_cnt_m  <= ROUNDS;
            core_in_m   <= core_wdata;
        end else if (core_busy_m) begin
            if (core_cnt_m == 0) begin
                core_busy_m <= 1'b0;
                core_rdata  <= cipher(core_in_m);
            end else begin
                core_cnt_m <= core_cnt_m - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_core_req", core_req, 0);
        check("rst_core_wdata", core_wdata, 0);
        check("rst_rdata", rdata, 0);
`ifdef TEA_ARB_WDOG_EN
        check("rst_err", err, 0);
`endif
    endtask

    task automatic rand_wdata();
        for (int s = 0; s < N; s++) wdata[32*s +: 32] = $urandom;
    endtask

    task automatic run_txn(input logic [N-1:0] mask, input bit drop, input bit stall);
        int          exp_w;
        int          lat;
        int          lat_exp;
        int          c0;
        bit          got;
        logic [31:0] orig;
        logic [31:0] rd_exp;
        exp_w = rr_expect(mask, mptr);
        req   = mask;
        c0    = creq_cnt;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = busy;
        end
        check("grant_seen", got, 1);
        if (!got) return;
        orig = slice(wdata, exp_w);
        check("gnt_id", gnt_id, exp_w);
        check("core_req_issue", core_req, 1);
        check("core_wdata", core_wdata, orig);
        if (stall) ack_hold = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < LAT + TMO_TB + 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("core_req_wait", core_req, 0);
                rand_wdata();
                if (drop) req[exp_w] = 1'b0;
            end
            got = (done != '0);
        end
        ack_hold = 1'b0;
        check("done_seen", got, 1);
        if (!got) return;
        lat_exp = stall ? (TMO_TB + 2) : LAT;
        rd_exp  = stall ? ERR_WORD : cipher(orig);
        check("latency", lat, lat_exp);
        check("done_vec", done, 1 << exp_w);
        check("rdata", rdata, rd_exp);
        check("busy_at_done", busy, 0);
        check("one_core_req", creq_cnt - c0, 1);
        @(negedge clk);
        check("done_width", done, 0);
        check("no_grant_in_done", busy, 0);
        check("rdata_hold", rdata, rd_exp);
        mptr = exp_w;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        bit          seen;
        bit          got;
        logic [N-1:0] m;

        repeat (2) @(negedge clk);
        check_reset_vals();
        prstb = 1'b1;
        mptr  = N - 1;

        // All requesters active: grants rotate 0,1,2,3,0.
        rand_wdata();
        for (int k = 0; k < 5; k++) run_txn(4'b1111, 1'b0, 1'b0);

        // Single requester 2 with a known plaintext.
        rand_wdata();
        wdata[95:64] = 32'h0000_0001;
        run_txn(4'b0100, 1'b0, 1'b0);

        // Requester 1 drops req right after its grant.
        rand_wdata();
        run_txn(4'b0010, 1'b1, 1'b0);

        // Randomized masks, plaintexts and early drops.
        for (int k = 0; k < 12; k++) begin
            rand_wdata();
            m = 4'($urandom_range(1, 15));
            run_txn(m, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Core ack held low out of reset: no grant until it rises.
        req      = '0;
        ack_hold = 1'b1;
        prstb    = 1'b0;
        repeat (2) @(negedge clk);
        prstb = 1'b1;
        mptr  = N - 1;
        req   = 4'b0001;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | core_req | busy;
        end
        check("no_grant_ack_low", seen, 0);
        ack_hold = 1'b0;
        rand_wdata();
        run_txn(4'b0001, 1'b0, 1'b0);

        // Reset in the middle of WAIT abandons the transaction.
        rand_wdata();
        req = 4'b1000;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = busy;
        end
        check("mid_rst_grant_seen", got, 1);
        repeat (3) @(negedge clk);
        prstb = 1'b0;
        @(negedge clk);
        check_reset_vals();
        req = '0;
        @(negedge clk);
        prstb = 1'b1;
        mptr  = N - 1;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | (|done);
        end
        check("no_done_after_rst", seen, 0);
        rand_wdata();
        run_txn(4'b1000, 1'b0, 1'b0);

`ifdef TEA_ARB_WDOG_EN
        // Core ack stuck low: watchdog fires, error word returned, err sticky.
        rand_wdata();
        run_txn(4'b0001, 1'b0, 1'b1);
        check("err_set", err, 1);
        rand_wdata();
        run_txn(4'b0010, 1'b0, 1'b0);
        check("err_sticky", err, 1);
        prstb = 1'b0;
        @(negedge clk);
        check("err_cleared", err, 0);
        prstb = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tea_arb.md
TEA_ARB -- requirements
Module: tea_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requester ports; legal range 2..8.
REQ-002 Parameter TMO, default 16'd511: watchdog limit in clk cycles; used only when TEA_ARB_WDOG_EN is defined.
REQ-003 Port list, one per line:
  clk          in   1       system clock; all logic on its rising edge
  prstb        in   1       reset, asynchronous, active-low
  req          in   NREQ    per-requester request, level; held until own done
  wdata        in   32*NREQ packed plaintext; slice n = wdata[32n+31:32n]
  done         out  NREQ    one-cycle pulse; result for requester n on rdata
  rdata        out  32      registered result; valid in the cycle done is high
  busy         out  1       high from grant until done
  gnt_id       out  clog2(NREQ)  index of the current or last granted requester
  core_req     out  1       to cipher core req
  core_wdata   out  32      to cipher core wdata
  core_ack     in   1       from cipher core ack; high = core idle
  core_rdata   in   32      from cipher core rdata
  err          out  1       sticky watchdog flag; exists only with TEA_ARB_WDOG_EN

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, encoded in the package enum.
REQ-005 IDLE: with core_ack=1 and any req bit set, the block SHALL pick a winner round-robin, starting at index ptr+1 mod NREQ, latch it into gnt_id, set busy and go to ISSUE.
REQ-006 IDLE with core_ack=0 (core still busy after reset or release) SHALL stay in IDLE and SHALL NOT grant.
REQ-007 ISSUE: core_req=1 and core_wdata=wdata slice[gnt_id] for exactly one cycle, then go to WAIT; core_req SHALL be 0 in every other state.
REQ-008 WAIT: the first cycle with core_ack=1 SHALL register core_rdata into rdata and go to DONE.
REQ-009 DONE: done[gnt_id]=1 for one cycle, busy cleared, ptr<=gnt_id, then go to IDLE; no grant in the DONE cycle.
REQ-010 Latency from grant to done SHALL be core round count + 3 cycles; back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-011 A requester that drops req after grant SHALL still receive its done pulse; the result is not discarded or retried.
REQ-012 A single active requester SHALL be re-granted on every IDLE visit; with all NREQ active, each SHALL be served once per NREQ grants.
REQ-013 wdata slice[gnt_id] SHALL be sampled only in ISSUE; later changes have no effect.
REQ-014 rdata SHALL hold its last value outside DONE.

Reset
REQ-015 prstb low SHALL force state=IDLE, ptr=NREQ-1, gnt_id=0, busy=0, done=0, core_req=0, core_wdata=0, rdata=0, err=0, and clear the watchdog count.
REQ-016 Reset asserted mid-operation SHALL abandon the transaction with no done pulse; after release, REQ-006 holds until core_ack=1.

Configuration
REQ-017 With TEA_ARB_WDOG_EN defined, a 16-bit counter SHALL count cycles spent in WAIT.
REQ-018 When the count equals TMO, the block SHALL set err, pulse done[gnt_id] with rdata=32'hDEAD_DEAD, and go to IDLE.
REQ-019 err SHALL clear only on reset.
REQ-020 Without TEA_ARB_WDOG_EN, the port err, the counter and TMO usage SHALL be absent, and WAIT SHALL wait indefinitely.

Structure
REQ-021 Package tea_arb_pkg SHALL hold the state enum, the NREQ default, and the constant ERR_WORD=32'hDEAD_DEAD.
REQ-022 The round-robin selection SHALL be a sub-module rr_pick: inputs req and ptr; outputs valid and idx; purely combinational.

Verification
REQ-023 The bench SHALL cover these directed scenarios, using a core model with 8 rounds:
  - Only req[2]=1 with wdata slice 2=32'h0000_0001 -> one core_req pulse with core_wdata=32'h0000_0001; done[2] 11 cycles after grant; rdata=model output.
  - req=4'b1111 held -> grant order 0,1,2,3,0; exactly one done per grant.
  - core_ack held 0 out of reset, req[0]=1 -> no core_req until core_ack rises.
  - req[1] dropped the cycle after grant -> done[1] still pulses.
  - prstb pulsed low during WAIT -> all outputs at reset values; no done.
  - With TEA_ARB_WDOG_EN and TMO=16'd20, core_ack stuck 0 -> err=1, done pulse, rdata=32'hDEAD_DEAD.
